// File: rtl/kernel3_gmem_c_m_axi_srl_fifo_ctrl.sv
// Control logic for an SRL-based FIFO with a registered output stage.
// Tracks SRL occupancy and head validity, and steers the SRL shift and tap-read strobes.
module kernel3_gmem_c_m_axi_srl_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  srl_we,
  output logic [DATA_WIDTH-1:0] srl_din,
  output logic [ADDR_WIDTH-1:0] srl_raddr,
  output logic                  srl_re,
  input  logic [DATA_WIDTH-1:0] srl_dout
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] srl_cnt_reg, srl_cnt_next;
  logic             dout_vld_reg, dout_vld_next;
  logic             push, pop_out, load;
  logic [CNT_W-1:0] tap;

  assign if_full_n = (srl_cnt_reg < CNT_MAX);

  // Strobes are suppressed during reset so the SRL never sees a shift that is being discarded.
  assign push    = clk_en & ~reset & if_write_ce & if_write & if_full_n;
  assign pop_out = clk_en & if_read_ce & if_read & dout_vld_reg;
  assign load    = clk_en & ~reset & (srl_cnt_reg != '0) &
                   (~dout_vld_reg | (if_read_ce & if_read));

  assign tap       = (srl_cnt_reg != '0) ? (srl_cnt_reg - CNT_W'(1)) : '0;
  assign srl_raddr = tap[ADDR_WIDTH-1:0];

  assign srl_we  = push;
  assign srl_re  = load;
  assign srl_din = if_din;
  assign if_dout = srl_dout;

  assign if_empty_n        = dout_vld_reg;
  assign if_num_data_valid = srl_cnt_reg + CNT_W'(dout_vld_reg);

  always_comb begin
    srl_cnt_next  = srl_cnt_reg;
    dout_vld_next = dout_vld_reg;
    if (clk_en) begin
      srl_cnt_next = srl_cnt_reg + CNT_W'(push) - CNT_W'(load);
      if (load)
        dout_vld_next = 1'b1;
      else if (pop_out)
        dout_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srl_cnt_reg  <= '0;
      dout_vld_reg <= 1'b0;
    end else begin
      srl_cnt_reg  <= srl_cnt_next;
      dout_vld_reg <= dout_vld_next;
    end
  end

endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_srl_fifo_ctrl.sv
// Self-checking bench: an SRL storage model around the controller, a directed vector table
// and hand-written fill/drain/stream/enable/reset sequences.
module tb_kernel3_gmem_c_m_axi_srl_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 63;

  logic          clk = 1'b0;
  logic          reset;
  logic          clk_en;
  logic          if_write_ce, if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read_ce, if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;
  logic [AW:0]   if_num_data_valid;
  logic          srl_we, srl_re;
  logic [DW-1:0] srl_din;
  logic [AW-1:0] srl_raddr;
  logic [DW-1:0] srl_dout = '0;

  logic [DW-1:0] srl_mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kernel3_gmem_c_m_axi_srl_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .if_num_data_valid(if_num_data_valid),
    .srl_we(srl_we), .srl_din(srl_din), .srl_raddr(srl_raddr), .srl_re(srl_re),
    .srl_dout(srl_dout)
  );

  // SRL storage model: shift in at tap 0, registered read of the pre-shift tap.
  always @(posedge clk) begin
    if (srl_we) begin
      srl_mem[0] <= srl_din;
      for (int i = 1; i < (1 << AW); i++) srl_mem[i] <= srl_mem[i-1];
    end
    if (srl_re) srl_dout <= srl_mem[srl_raddr];
  end

  typedef struct {
    logic          ce, wce, wr;
    logic [DW-1:0] din;
    logic          rce, rd;
    logic          e_we, e_re;
    logic [AW-1:0] e_raddr;
    logic          e_empty_n, e_full_n;
    logic [AW:0]   e_num;
    logic          chk_dout;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t vecs [0:16];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic wce, input logic wr, input logic [DW-1:0] din,
                       input logic rce, input logic rd);
    clk_en = ce; if_write_ce = wce; if_write = wr; if_din = din;
    if_read_ce = rce; if_read = rd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    tick();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic ce, wce, wr, input logic [DW-1:0] din, input logic rce, rd,
                              input logic we, re, input logic [AW-1:0] ra,
                              input logic emp, ful, input logic [AW:0] num,
                              input logic cd, input logic [DW-1:0] dout);
    vec_t v;
    v.ce = ce; v.wce = wce; v.wr = wr; v.din = din; v.rce = rce; v.rd = rd;
    v.e_we = we; v.e_re = re; v.e_raddr = ra;
    v.e_empty_n = emp; v.e_full_n = ful; v.e_num = num; v.chk_dout = cd; v.e_dout = dout;
    return v;
  endfunction

  initial begin
    //            ce wce wr din           rce rd  we re ra  emp ful num cd dout
    vecs[0]  = mk(1, 1, 0, 32'h0,        1, 0,  0, 0, 0,  0, 1, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 1, 32'hA5A5A5A5, 1, 0,  1, 0, 0,  0, 1, 1, 0, 32'h0);
    vecs[2]  = mk(1, 1, 0, 32'h0,        1, 0,  0, 1, 0,  1, 1, 1, 1, 32'hA5A5A5A5);
    vecs[3]  = mk(1, 1, 0, 32'h0,        1, 0,  0, 0, 0,  1, 1, 1, 1, 32'hA5A5A5A5);
    vecs[4]  = mk(1, 1, 1, 32'h11,       1, 1,  1, 0, 0,  0, 1, 1, 0, 32'h0);
    vecs[5]  = mk(1, 1, 1, 32'h22,       1, 1,  1, 1, 0,  1, 1, 2, 1, 32'h11);
    vecs[6]  = mk(1, 1, 1, 32'h33,       1, 1,  1, 1, 0,  1, 1, 2, 1, 32'h22);
    vecs[7]  = mk(0, 1, 1, 32'h44,       1, 1,  0, 0, 0,  1, 1, 2, 1, 32'h22);
    vecs[8]  = mk(1, 0, 1, 32'h55,       0, 1,  0, 0, 0,  1, 1, 2, 1, 32'h22);
    vecs[9]  = mk(1, 1, 0, 32'h0,        1, 1,  0, 1, 0,  1, 1, 1, 1, 32'h33);
    vecs[10] = mk(1, 1, 0, 32'h0,        1, 1,  0, 0, 0,  0, 1, 0, 0, 32'h0);
    vecs[11] = mk(1, 1, 0, 32'h0,        1, 1,  0, 0, 0,  0, 1, 0, 0, 32'h0);
    vecs[12] = mk(1, 1, 1, 32'h66,       1, 0,  1, 0, 0,  0, 1, 1, 0, 32'h0);
    vecs[13] = mk(1, 1, 1, 32'h77,       1, 0,  1, 1, 0,  1, 1, 2, 1, 32'h66);
    vecs[14] = mk(1, 1, 1, 32'h88,       1, 0,  1, 0, 0,  1, 1, 3, 1, 32'h66);
    vecs[15] = mk(1, 1, 0, 32'h0,        1, 0,  0, 0, 1,  1, 1, 3, 1, 32'h66);
    vecs[16] = mk(1, 1, 0, 32'h0,        1, 1,  0, 1, 1,  1, 1, 2, 1, 32'h77);

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_we", 32'(srl_we), 32'd0);
    chk("rst_re", 32'(srl_re), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_full_n", 32'(if_full_n), 32'd1);
    chk("rst_empty_n", 32'(if_empty_n), 32'd0);
    chk("rst_num", 32'(if_num_data_valid), 32'd0);
    chk("rst_raddr", 32'(srl_raddr), 32'd0);

    // Directed vector table: strobes before the edge, state after it.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].ce, vecs[i].wce, vecs[i].wr, vecs[i].din, vecs[i].rce, vecs[i].rd);
      #2;
      $display("vec %0d: we=%0b re=%0b raddr=%0d", i, srl_we, srl_re, srl_raddr);
      chk($sformatf("v%0d_we", i), 32'(srl_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_re", i), 32'(srl_re), 32'(vecs[i].e_re));
      chk($sformatf("v%0d_raddr", i), 32'(srl_raddr), 32'(vecs[i].e_raddr));
      chk($sformatf("v%0d_srl_din", i), srl_din, vecs[i].din);
      tick();
      chk($sformatf("v%0d_empty_n", i), 32'(if_empty_n), 32'(vecs[i].e_empty_n));
      chk($sformatf("v%0d_full_n", i), 32'(if_full_n), 32'(vecs[i].e_full_n));
      chk($sformatf("v%0d_num", i), 32'(if_num_data_valid), 32'(vecs[i].e_num));
      if (vecs[i].chk_dout) chk($sformatf("v%0d_dout", i), if_dout, vecs[i].e_dout);
    end

    // Fill: 70 offered, 63 accepted.
    do_reset();
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(i), 1'b1, 1'b0);
      tick();
    end
    $display("fill: num=%0d full_n=%0b", if_num_data_valid, if_full_n);
    chk("fill_full_n", 32'(if_full_n), 32'd0);
    chk("fill_num", 32'(if_num_data_valid), 32'd63);

    // Drain: one word per cycle, in order.
    for (int i = 0; i < 63; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
      #1;
      chk($sformatf("drain_vld%0d", i), 32'(if_empty_n), 32'd1);
      chk($sformatf("drain_dout%0d", i), if_dout, 32'(i));
      tick();
    end
    $display("drain: num=%0d empty_n=%0b", if_num_data_valid, if_empty_n);
    chk("drain_empty_n", 32'(if_empty_n), 32'd0);
    chk("drain_num", 32'(if_num_data_valid), 32'd0);

    // Streaming with one word in the SRL behind the head: no bubbles.
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'd200, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b1, 32'd201, 1'b1, 1'b0); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(202 + i), 1'b1, 1'b1);
      #1;
      $display("stream %0d: dout=%0d num=%0d", i, if_dout, if_num_data_valid);
      chk($sformatf("stream_vld%0d", i), 32'(if_empty_n), 32'd1);
      chk($sformatf("stream_dout%0d", i), if_dout, 32'(200 + i));
      chk($sformatf("stream_num%0d", i), 32'(if_num_data_valid), 32'd2);
      tick();
    end

    // Enable gating with 5 words stored.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(300 + i), 1'b1, 1'b0);
      tick();
    end
    chk("gate_num_before", 32'(if_num_data_valid), 32'd5);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1);
      #1;
      chk($sformatf("gate_we%0d", i), 32'(srl_we), 32'd0);
      chk($sformatf("gate_re%0d", i), 32'(srl_re), 32'd0);
      tick();
      chk($sformatf("gate_num%0d", i), 32'(if_num_data_valid), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
      #1;
      $display("gate readout %0d: dout=%0d", i, if_dout);
      chk($sformatf("gate_dout%0d", i), if_dout, 32'(300 + i));
      tick();
    end
    chk("gate_empty_after", 32'(if_empty_n), 32'd0);

    // Reset mid-stream with 20 words stored.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'(400 + i), 1'b1, 1'b0);
      tick();
    end
    chk("mrst_num_before", 32'(if_num_data_valid), 32'd20);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'hBEEF, 1'b1, 1'b1);
    #1;
    chk("mrst_we", 32'(srl_we), 32'd0);
    chk("mrst_re", 32'(srl_re), 32'd0);
    tick();
    reset = 1'b0;
    chk("mrst_num", 32'(if_num_data_valid), 32'd0);
    chk("mrst_empty_n", 32'(if_empty_n), 32'd0);
    chk("mrst_full_n", 32'(if_full_n), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0); tick();
    chk("mrst_lat1_empty_n", 32'(if_empty_n), 32'd0);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0); tick();
    $display("mid-reset repush: empty_n=%0b dout=0x%0h", if_empty_n, if_dout);
    chk("mrst_lat2_empty_n", 32'(if_empty_n), 32'd1);
    chk("mrst_dout", if_dout, 32'h1);
    chk("mrst_num_after", 32'(if_num_data_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
